// File: rtl/mcycle_seq_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer:
// operation codes, FSM states and small op-decoding helpers.
package mcycle_seq_pkg;

  typedef enum logic [1:0] {
    MC_MULU = 2'b00,
    MC_MULS = 2'b01,
    MC_DIVU = 2'b10,
    MC_DIVS = 2'b11
  } mc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mc_state_e;

  function automatic logic op_is_div(input mc_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mc_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mcycle_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply add step and the
// divide trial subtract; carry is the carry-out (add) or borrow (sub).
module mcycle_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum,
  output logic             carry
);

  logic [WIDTH+1:0] full;

  always_comb begin
    if (sub) full = {1'b0, a} - {2'b00, b};
    else     full = {1'b0, a} + {2'b00, b};
  end

  assign sum   = full[WIDTH:0];
  assign carry = full[WIDTH+1];

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle multiply/divide sequencer: one shift-and-add (multiply) or
// restoring shift-and-subtract (divide) step per clock, on operand magnitudes.
module mcycle_seq
  import mcycle_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  mc_state_e        state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;
  logic             done_q, done_d;

  mc_op_e           op_in;
  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in  = mc_op_e'(MCycleOp);
  assign accept = Start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign a_neg  = op_is_signed(op_in) & Operand1[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) & Operand2[WIDTH-1];
  assign a_mag  = a_neg ? -Operand1 : Operand1;
  assign b_mag  = b_neg ? -Operand2 : Operand2;

  // hi/lo double as {hi,lo} product accumulator (multiply) or rem/quo (divide).
  logic [WIDTH:0]     add_a, add_sum, mul_ext;
  logic               add_carry;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin, rem_fin;

  assign add_a = is_div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};

  mcycle_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (add_a),
    .b     (opnd_q),
    .sub   (is_div_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign mul_ext  = lo_q[0] ? add_sum : {1'b0, hi_q};
  assign prod_fin = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_fin  = neg_q ? -lo_q : lo_q;
  assign rem_fin  = rem_neg_q ? -hi_q : hi_q;

  always_comb begin
    // NOTE: every _d gets a default from its _q first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    result1_d = result1_q;
    result2_d = result2_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (count_q == LAST) begin
          if (is_div_q) begin
            result1_d = quo_fin;
            result2_d = rem_fin;
          end else begin
            result1_d = prod_fin[WIDTH-1:0];
            result2_d = prod_fin[2*WIDTH-1:WIDTH];
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
          if (is_div_q) begin
            if (!add_carry) begin
              hi_d = add_sum[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_ext[WIDTH:1];
            lo_d = {mul_ext[0], lo_q[WIDTH-1:1]};
          end
        end
      end
      default: begin
        if (accept) begin
          state_d  = ST_RUN;
          is_div_d = op_is_div(op_in);
          neg_d    = a_neg ^ b_neg;
          count_d  = '0;
          if (op_is_div(op_in)) begin
            opnd_d    = b_mag;
            hi_d      = '0;
            lo_d      = a_mag;
            rem_neg_d = a_neg;
            // Divide by zero preloads the final answer and skips the iterations.
            if (Operand2 == '0) begin
              hi_d      = Operand1;
              lo_d      = '1;
              neg_d     = 1'b0;
              rem_neg_d = 1'b0;
              count_d   = LAST;
            end
          end else begin
            opnd_d    = a_mag;
            hi_d      = '0;
            lo_d      = b_mag;
            rem_neg_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      result1_q <= '0;
      result2_q <= '0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
      done_q    <= done_d;
    end
  end

  assign Busy    = accept || (state_q == ST_RUN);
  assign Done    = done_q;
  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_seq.sv
// Directed and randomized checks of mcycle_seq against an arithmetic
// reference model built on 64-bit integer multiply/divide.
module tb_mcycle_seq;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  mcycle_seq #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  // Returns {Result2, Result1} as the arithmetic definition says they should be.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; presents a request and lets the next edge accept it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep, input string tag);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    #1;
    check({tag, ":busy_req"}, 64'(Busy), 64'd1);
    @(negedge CLK);
    if (!keep) begin
      Start    = 1'b0;
      MCycleOp = 2'($urandom_range(3));
      Operand1 = $urandom;
      Operand2 = $urandom;
    end
  endtask

  task automatic wait_done(input int start_cyc, input int exp_lat, input string tag);
    int cycles;
    bit busy_ok;
    cycles  = start_cyc;
    busy_ok = 1'b1;
    while (Done !== 1'b1 && cycles < 100) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(negedge CLK);
      cycles++;
    end
    check({tag, ":latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, ":busy_run"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic check_results(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    logic [63:0] exp;
    exp = ref_model(op, a, b);
    check({tag, ":r1"}, 64'(Result1), 64'(exp[31:0]));
    check({tag, ":r2"}, 64'(Result2), 64'(exp[63:32]));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] exp;
    int          lat;
    exp = ref_model(op, a, b);
    lat = (op[1] && b == 32'd0) ? 2 : 34;
    issue(op, a, b, 1'b0, tag);
    wait_done(1, lat, tag);
    check_results(op, a, b, tag);
    @(negedge CLK);
    check({tag, ":done_pulse"}, 64'(Done), 64'd0);
    check({tag, ":held"}, {Result2, Result1}, exp);
  endtask

  initial begin
    RESETn   = 1'b0;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;
    #12;
    check("reset:r1", 64'(Result1), 64'd0);
    check("reset:r2", 64'(Result2), 64'd0);
    check("reset:done", 64'(Done), 64'd0);
    check("reset:busy", 64'(Busy), 64'd0);
    Start = 1'b1;
    #1;
    check("reset:busy_eq_start", 64'(Busy), 64'd1);
    Start = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "muls_neg");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "muls_intmin");
    run_op(2'b10, 32'd100, 32'd7, "divu");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "divs_neg");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "divs_ovf");
    run_op(2'b10, 32'd5, 32'd0, "divu_zero");
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, "divs_zero");

    // A Start pulse mid-run with different operands must be ignored.
    issue(2'b00, 32'h0000_1234, 32'h0000_5678, 1'b0, "midrun");
    repeat (10) @(negedge CLK);
    Start    = 1'b1;
    MCycleOp = 2'b10;
    Operand1 = 32'd999;
    Operand2 = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    wait_done(12, 34, "midrun");
    check_results(2'b00, 32'h0000_1234, 32'h0000_5678, "midrun");
    @(negedge CLK);

    // Start held through DONE launches the second operation back to back.
    issue(2'b00, 32'd3, 32'd5, 1'b1, "b2b_a");
    MCycleOp = 2'b10;
    Operand1 = 32'd1000;
    Operand2 = 32'd9;
    wait_done(1, 34, "b2b_a");
    check_results(2'b00, 32'd3, 32'd5, "b2b_a");
    @(negedge CLK);
    Start    = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    wait_done(1, 34, "b2b_b");
    check_results(2'b10, 32'd1000, 32'd9, "b2b_b");
    @(negedge CLK);

    // Asynchronous reset in the middle of an operation.
    issue(2'b00, 32'd123, 32'd456, 1'b0, "rst_mid");
    repeat (9) @(negedge CLK);
    RESETn = 1'b0;
    #1;
    check("rst_mid:busy", 64'(Busy), 64'd0);
    check("rst_mid:done", 64'(Done), 64'd0);
    check("rst_mid:r1", 64'(Result1), 64'd0);
    check("rst_mid:r2", 64'(Result2), 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    run_op(2'b00, 32'd6, 32'd7, "after_rst");

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
